// File: rtl/interrupt_controller.sv
// Interrupt entry/exit sequencer: NMI edge detect, maskable INT, one nesting level (NMI over INT).
// Optional INTC_INT_LATCH_EN makes INT rising-edge latched instead of level sensitive.
module interrupt_controller #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned NMI_VECTOR = 27,
    parameter int unsigned INT_VECTOR = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             NMI,
    input  logic             INT,
    input  logic             INT_Disable,
    input  logic             fetch_boundary,
    input  logic             iret,
    input  logic [WIDTH-1:0] pc_in,
    output logic [1:0]       int_src,
    output logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] nmi_vec,
    output logic [WIDTH-1:0] int_vec,
    output logic             INA,
    output logic             in_service
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        SVC_INT      = 2'd1,
        SVC_NMI      = 2'd2,
        SVC_NMI_NEST = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             nmi_q, nmi_d;
    logic             nmi_pending_q, nmi_pending_d;
    logic [WIDTH-1:0] epc_int_q, epc_int_d;
    logic [WIDTH-1:0] epc_nmi_q, epc_nmi_d;
    logic             nmi_edge;
    logic             int_ok;
    logic             take_nmi;
    logic             take_int;

    assign nmi_vec = WIDTH'(NMI_VECTOR);
    assign int_vec = WIDTH'(INT_VECTOR);

    assign nmi_d    = NMI;
    assign nmi_edge = NMI & ~nmi_q;

`ifdef INTC_INT_LATCH_EN
    logic int_q, int_d;
    logic int_pending_q, int_pending_d;

    assign int_d         = INT;
    assign int_pending_d = (int_pending_q & ~take_int) | (INT & ~int_q);
    assign int_ok        = int_pending_q & ~INT_Disable;

    always_ff @(posedge clk) begin
        if (rst) begin
            int_q         <= 1'b0;
            int_pending_q <= 1'b0;
        end else begin
            int_q         <= int_d;
            int_pending_q <= int_pending_d;
        end
    end
`else
    assign int_ok = INT & ~INT_Disable;
`endif

    // int_src and INA are Mealy so the PC register loads the vector on the same edge.
    always_comb begin
        state_d   = state_q;
        int_src   = 2'b00;
        INA       = 1'b0;
        take_nmi  = 1'b0;
        take_int  = 1'b0;
        epc_int_d = epc_int_q;
        epc_nmi_d = epc_nmi_q;
        case (state_q)
            IDLE: begin
                if (fetch_boundary && nmi_pending_q) begin
                    int_src   = 2'b01;
                    take_nmi  = 1'b1;
                    epc_nmi_d = pc_in;
                    state_d   = SVC_NMI;
                end else if (fetch_boundary && int_ok) begin
                    int_src   = 2'b10;
                    INA       = 1'b1;
                    take_int  = 1'b1;
                    epc_int_d = pc_in;
                    state_d   = SVC_INT;
                end
            end
            SVC_INT: begin
                if (iret) begin
                    int_src = 2'b11;
                    state_d = IDLE;
                end else if (fetch_boundary && nmi_pending_q) begin
                    int_src   = 2'b01;
                    take_nmi  = 1'b1;
                    epc_nmi_d = pc_in;
                    state_d   = SVC_NMI_NEST;
                end
            end
            SVC_NMI: begin
                if (iret) begin
                    int_src = 2'b11;
                    state_d = IDLE;
                end
            end
            SVC_NMI_NEST: begin
                if (iret) begin
                    int_src = 2'b11;
                    state_d = SVC_INT;
                end
            end
            default: state_d = IDLE;
        endcase
        nmi_pending_d = (nmi_pending_q & ~take_nmi) | nmi_edge;
    end

    always_comb begin
        case (state_q)
            SVC_INT:              epc = epc_int_q;
            SVC_NMI, SVC_NMI_NEST: epc = epc_nmi_q;
            default:              epc = '0;
        endcase
    end

    assign in_service = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            nmi_q         <= 1'b0;
            nmi_pending_q <= 1'b0;
            epc_int_q     <= '0;
            epc_nmi_q     <= '0;
        end else begin
            state_q       <= state_d;
            nmi_q         <= nmi_d;
            nmi_pending_q <= nmi_pending_d;
            epc_int_q     <= epc_int_d;
            epc_nmi_q     <= epc_nmi_d;
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Table-driven bench for interrupt_controller; expectations follow INTC_INT_LATCH_EN when defined.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        rst, NMI, INT, INT_Disable, fetch_boundary, iret;
  logic [31:0] pc_in;
  logic [1:0]  int_src;
  logic [31:0] epc, nmi_vec, int_vec;
  logic        INA, in_service;

  always #5 clk = ~clk;

  interrupt_controller #(
    .WIDTH(32),
    .NMI_VECTOR(27),
    .INT_VECTOR(28)
  ) dut (
    .clk(clk),
    .rst(rst),
    .NMI(NMI),
    .INT(INT),
    .INT_Disable(INT_Disable),
    .fetch_boundary(fetch_boundary),
    .iret(iret),
    .pc_in(pc_in),
    .int_src(int_src),
    .epc(epc),
    .nmi_vec(nmi_vec),
    .int_vec(int_vec),
    .INA(INA),
    .in_service(in_service)
  );

  typedef struct {
    logic        rst, nmi, intr, dis, fb, iret;
    logic [31:0] pc;
    logic [1:0]  src;
    logic        ina, svc;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs[$];
  int   applied = 0;
  int   miscompares = 0;
  logic done = 1'b0;

  task automatic add(input logic r, input logic n, input logic i, input logic d,
                     input logic f, input logic ir, input int p,
                     input logic [1:0] s, input logic a, input logic sv, input int e);
    vec_t v;
    v.rst = r; v.nmi = n; v.intr = i; v.dis = d; v.fb = f; v.iret = ir;
    v.pc = p; v.src = s; v.ina = a; v.svc = sv; v.epc = e;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    if (!done) begin
      miscompares++;
      $display("FAIL timeout: only %0d of %0d vectors applied", applied, vecs.size());
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
    end
  end

  initial begin
    //   rst N  I  dis fb iret pc   src   ina svc epc
    add(1, 1, 1, 0, 0, 0, 0,  2'b00, 0, 0, 0);   // 0  reset, second cycle
    add(0, 0, 1, 0, 0, 0, 0,  2'b00, 0, 0, 0);   // 1  INT rises, no boundary
    add(0, 0, 1, 0, 1, 0, 5,  2'b10, 1, 0, 0);   // 2  INT taken
    add(0, 0, 1, 0, 0, 0, 6,  2'b00, 0, 1, 5);   // 3
    add(0, 0, 1, 0, 1, 0, 7,  2'b00, 0, 1, 5);   // 4  no INT re-take
    add(0, 0, 0, 0, 0, 1, 7,  2'b11, 0, 1, 5);   // 5  iret
    add(0, 0, 0, 0, 0, 0, 7,  2'b00, 0, 0, 0);   // 6
    add(0, 1, 1, 0, 0, 0, 8,  2'b00, 0, 0, 0);   // 7  NMI edge + INT
    add(0, 1, 1, 0, 1, 0, 9,  2'b01, 0, 0, 0);   // 8  NMI wins
    add(0, 1, 1, 0, 0, 0, 9,  2'b00, 0, 1, 9);   // 9
    add(0, 1, 1, 0, 1, 0, 10, 2'b00, 0, 1, 9);   // 10 SVC_NMI ignores INT
    add(0, 0, 1, 0, 0, 1, 10, 2'b11, 0, 1, 9);   // 11 iret
    add(0, 0, 1, 0, 1, 0, 5,  2'b10, 1, 0, 0);   // 12 INT now taken
    add(0, 1, 0, 0, 0, 0, 12, 2'b00, 0, 1, 5);   // 13 NMI edge in SVC_INT
    add(0, 1, 0, 0, 1, 0, 12, 2'b01, 0, 1, 5);   // 14 nest
    add(0, 1, 0, 0, 0, 0, 12, 2'b00, 0, 1, 12);  // 15
    add(0, 1, 0, 0, 1, 0, 13, 2'b00, 0, 1, 12);  // 16 nest accepts nothing
    add(0, 0, 0, 0, 0, 1, 13, 2'b11, 0, 1, 12);  // 17 first iret
    add(0, 0, 0, 0, 0, 0, 13, 2'b00, 0, 1, 5);   // 18 back in SVC_INT
    add(0, 0, 0, 0, 0, 1, 13, 2'b11, 0, 1, 5);   // 19 second iret
    add(0, 0, 0, 0, 0, 0, 13, 2'b00, 0, 0, 0);   // 20
    add(0, 1, 0, 0, 1, 0, 20, 2'b00, 0, 0, 0);   // 21 edge same cycle as boundary
    add(0, 1, 0, 0, 1, 0, 21, 2'b01, 0, 0, 0);   // 22
    add(0, 0, 0, 0, 0, 0, 21, 2'b00, 0, 1, 21);  // 23
    add(0, 1, 0, 0, 0, 0, 21, 2'b00, 0, 1, 21);  // 24 edge in SVC_NMI
    add(0, 1, 0, 0, 1, 0, 22, 2'b00, 0, 1, 21);  // 25 stays pending
    add(0, 0, 0, 0, 0, 1, 22, 2'b11, 0, 1, 21);  // 26
    add(0, 0, 0, 0, 1, 0, 23, 2'b01, 0, 0, 0);   // 27 pending NMI taken
    add(0, 0, 0, 0, 0, 1, 23, 2'b11, 0, 1, 23);  // 28
    add(0, 0, 1, 1, 1, 0, 30, 2'b00, 0, 0, 0);   // 29 masked
    add(0, 0, 1, 1, 1, 0, 31, 2'b00, 0, 0, 0);   // 30
    add(0, 0, 1, 1, 1, 0, 32, 2'b00, 0, 0, 0);   // 31
    add(0, 0, 0, 1, 1, 0, 33, 2'b00, 0, 0, 0);   // 32
`ifdef INTC_INT_LATCH_EN
    add(0, 0, 0, 0, 1, 0, 34, 2'b10, 1, 0, 0);   // 33 latched INT taken
    add(0, 0, 0, 0, 0, 1, 34, 2'b11, 0, 1, 34);  // 34
`else
    add(0, 0, 0, 0, 1, 0, 34, 2'b00, 0, 0, 0);   // 33 level INT gone
    add(0, 0, 0, 0, 0, 1, 34, 2'b00, 0, 0, 0);   // 34 iret in IDLE ignored
`endif
    add(0, 0, 1, 0, 0, 0, 39, 2'b00, 0, 0, 0);   // 35
    add(0, 0, 1, 0, 1, 0, 40, 2'b10, 1, 0, 0);   // 36
    add(0, 1, 0, 0, 0, 0, 40, 2'b00, 0, 1, 40);  // 37 NMI edge
    add(0, 1, 0, 0, 1, 1, 40, 2'b11, 0, 1, 40);  // 38 iret beats boundary
    add(0, 0, 0, 0, 0, 0, 40, 2'b00, 0, 0, 0);   // 39
    add(0, 0, 0, 0, 1, 0, 41, 2'b01, 0, 0, 0);   // 40 NMI from IDLE
    add(0, 0, 0, 0, 0, 0, 41, 2'b00, 0, 1, 41);  // 41
    add(0, 0, 0, 0, 0, 1, 41, 2'b11, 0, 1, 41);  // 42
    add(0, 0, 0, 0, 0, 0, 41, 2'b00, 0, 0, 0);   // 43 not nested: IDLE
    add(0, 0, 1, 0, 0, 0, 49, 2'b00, 0, 0, 0);   // 44
    add(0, 0, 1, 0, 1, 0, 50, 2'b10, 1, 0, 0);   // 45
    add(0, 1, 0, 0, 0, 0, 50, 2'b00, 0, 1, 50);  // 46 NMI edge
    add(1, 1, 0, 0, 0, 0, 50, 2'b00, 0, 1, 50);  // 47 reset mid-handler
    add(0, 0, 0, 0, 1, 0, 51, 2'b00, 0, 0, 0);   // 48 pending discarded
    add(0, 0, 0, 0, 1, 0, 52, 2'b00, 0, 0, 0);   // 49

    rst = 1'b1; NMI = 1'b1; INT = 1'b1; INT_Disable = 1'b0;
    fetch_boundary = 1'b0; iret = 1'b0; pc_in = '0;
    @(posedge clk);
    @(negedge clk);
    if (int_src !== 2'b00 || INA !== 1'b0 || in_service !== 1'b0 || epc !== '0) begin
      miscompares++;
      $display("FAIL reset: got src=%b ina=%b svc=%b epc=%0d, want src=00 ina=0 svc=0 epc=0",
               int_src, INA, in_service, epc);
    end

    for (int unsigned k = 0; k < vecs.size(); k++) begin
      if (k != 0) @(negedge clk);
      rst = vecs[k].rst; NMI = vecs[k].nmi; INT = vecs[k].intr;
      INT_Disable = vecs[k].dis; fetch_boundary = vecs[k].fb;
      iret = vecs[k].iret; pc_in = vecs[k].pc;
      #2;
      applied++;
      if (int_src !== vecs[k].src || INA !== vecs[k].ina ||
          in_service !== vecs[k].svc || epc !== vecs[k].epc ||
          nmi_vec !== 32'd27 || int_vec !== 32'd28) begin
        miscompares++;
        $display("FAIL vec%0d: got src=%b ina=%b svc=%b epc=%0d nv=%0d iv=%0d, want src=%b ina=%b svc=%b epc=%0d nv=27 iv=28",
                 k, int_src, INA, in_service, epc, nmi_vec, int_vec,
                 vecs[k].src, vecs[k].ina, vecs[k].svc, vecs[k].epc);
      end
    end

    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Sequences interrupt entry and exit for the multi-cycle CPU.
- Detects NMI edges and maskable INT requests, and prioritises NMI over INT.
- Accepts an interrupt only at an instruction boundary signalled by the control unit.
- Drives the 2-bit select of the PC interrupt multiplexer, saves the return PC, and restores it on return-from-interrupt. Supports one nesting level (NMI may preempt an INT handler).

Parameters:
- WIDTH, 32, PC/address width.
- NMI_VECTOR, 27, NMI handler address. Driven on nmi_vec; integrator wires it to mux input b.
- INT_VECTOR, 28, INT handler address. Driven on int_vec; integrator wires it to mux input c.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- NMI  input  1  non-maskable request, rising-edge sensitive.
- INT  input  1  maskable request, level sensitive.
- INT_Disable  input  1  masks INT while high.
- fetch_boundary  input  1  high for exactly one cycle when the control unit is in the fetch state.
- iret  input  1  high for one cycle when a return-from-interrupt instruction completes.
- pc_in  input  WIDTH  PC of the next instruction to execute.
- int_src  output  2  00 normal, 01 NMI vector, 10 INT vector, 11 return to epc.
- epc  output  WIDTH  return PC currently in use (mux input d).
- nmi_vec  output  WIDTH  constant NMI_VECTOR.
- int_vec  output  WIDTH  constant INT_VECTOR.
- INA  output  1  one-cycle INT acknowledge pulse.
- in_service  output  1  high while any handler is active.

Behaviour:
- Reset values: int_src=00, epc=0, INA=0, in_service=0. nmi_pending, epc_int and epc_nmi cleared; state=IDLE. Reset mid-handler discards all nesting and pending state.
- NMI edge detection:
  - NMI is registered once (nmi_q). A rising edge is NMI & ~nmi_q.
  - An edge sets nmi_pending. nmi_pending clears only when the NMI is taken.
  - An edge arriving while the NMI handler is active stays pending.
- int_ok = INT & ~INT_Disable, sampled every cycle, with no internal latch.
- States:
  - IDLE.
  - SVC_INT: INT handler active.
  - SVC_NMI: NMI handler active, entered from IDLE.
  - SVC_NMI_NEST: NMI handler active, preempted an INT handler.
- int_src is a Mealy output: combinational from current state, pending flags, fetch_boundary and iret. This lets the CPU PC register load the vector on the same edge. All state changes are registered on that edge.
- Transitions:
  - IDLE, fetch_boundary & nmi_pending: int_src=01; epc_nmi<=pc_in; go to SVC_NMI.
  - IDLE, fetch_boundary & ~nmi_pending & int_ok: int_src=10; epc_int<=pc_in; INA=1 for this cycle; go to SVC_INT.
  - SVC_INT, fetch_boundary & nmi_pending: int_src=01; epc_nmi<=pc_in; go to SVC_NMI_NEST. INT is never re-taken in SVC_INT.
  - SVC_INT, iret: int_src=11; go to IDLE.
  - SVC_NMI, iret: int_src=11; go to IDLE.
  - SVC_NMI_NEST, iret: int_src=11; go to SVC_INT. epc_int is preserved.
  - SVC_NMI and SVC_NMI_NEST do not accept any new interrupt.
- epc output: epc_nmi in SVC_NMI/SVC_NMI_NEST, epc_int in SVC_INT, 0 in IDLE.
- in_service = (state != IDLE).
- Simultaneous events:
  - NMI pending and int_ok at the same boundary: NMI wins; INT is not acknowledged.
  - iret and fetch_boundary in the same cycle: iret wins; a pending request waits for the next boundary.
  - iret in IDLE: ignored, int_src=00.
- No arithmetic is performed. epc is an exact copy of pc_in, width WIDTH.

Optional Feature:
- Macro: INTC_INT_LATCH_EN.
- Defined:
  - Rising edges of INT set int_pending.
  - int_ok becomes int_pending & ~INT_Disable.
  - int_pending clears when the INT is taken, or on rst.
  - A request masked by INT_Disable stays pending until unmasked.
- Undefined: INT is level sensitive as described above, with no int_pending register.

Test Plan:
- rst=1 for 2 cycles with NMI=INT=1: int_src=00, INA=0, in_service=0, epc=0.
- INT=1, INT_Disable=0, pc_in=5, fetch_boundary pulse: int_src=10 in that cycle, INA one-cycle pulse, next cycle epc=5 and in_service=1. Then iret pulse: int_src=11, epc=5, then IDLE.
- NMI rising edge plus INT=1 simultaneously, pc_in=9, boundary: int_src=01, INA=0, epc=9. After iret, next boundary with INT still 1: int_src=10.
- In SVC_INT (epc=5), NMI edge, pc_in=12, boundary: int_src=01, epc=12. First iret: int_src=11, epc=12, state SVC_INT with epc=5. Second iret: int_src=11, epc=5, then IDLE.
- INT=1, INT_Disable=1 over 3 boundaries: int_src=00, INA=0. With INTC_INT_LATCH_EN: pulse INT while disabled, deassert INT, clear INT_Disable, boundary: int_src=10.
- iret and fetch_boundary same cycle with NMI pending in SVC_INT: int_src=11. At the next boundary int_src=01, state SVC_NMI (not nested).
